// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and constants for the reaction timer controller.
//   state_e        : controller FSM states
//   ERR_CODE       : value shown on a false start ("EEEE")
//   MAX_MS_DEFAULT : reaction count saturation / timeout in ms
//   LFSR_TAPS      : feedback mask for the 16-bit Fibonacci LFSR
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StGo,
    StResult,
    StFalseStart
  } state_e;

  localparam logic [15:0] ERR_CODE       = 16'hEEEE;
  localparam int unsigned MAX_MS_DEFAULT = 9999;
  // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Player-facing bus of the reaction timer controller.
//   btn_start, btn_react : synchronized, debounced button levels
//   led_go               : GO lamp
//   number               : display value (0..MAX_MS or ERR_CODE)
//   done                 : a result or false-start code is on display
// master = button/display side, slave = the controller.
interface reaction_timer_ctrl_if;
  logic        btn_start;
  logic        btn_react;
  logic        led_go;
  logic [15:0] number;
  logic        done;

  modport master (
    output btn_start, btn_react,
    input  led_go, number, done
  );

  modport slave (
    input  btn_start, btn_react,
    output led_go, number, done
  );
endinterface

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_DIV-1 and pulses tick on the
// terminal count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the current millisecond from zero
//   tick     : one-cycle pulse every MS_DIV cycles
module ms_tick_gen #(
  parameter int unsigned MS_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(MS_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller feeding the seven-segment display driver.
// Start press -> random wait -> GO lamp -> count ms until react press.
//   clk, rst : clock, synchronous active-high reset
//   bus      : buttons in; led_go, number, done out (all registered)
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned MS_DIV       = 100_000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned MAX_MS       = MAX_MS_DEFAULT,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  reaction_timer_ctrl_if.slave bus
);

  localparam int unsigned DELAY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
  localparam int unsigned DELAY_W   = ($clog2(DELAY_MAX + 1) > 12) ? $clog2(DELAY_MAX + 1) : 12;

  state_e               state_q, state_d;
  logic                 start_prev_q, react_prev_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [13:0]          ms_cnt_q, ms_cnt_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [15:0]          number_q, number_d;
  logic                 done_q, done_d;
  logic                 led_go_q, led_go_d;

  logic start_press, react_press, ms_tick, tick_clr, wait_last, go_last;

  assign start_press = bus.btn_start & ~start_prev_q;
  assign react_press = bus.btn_react & ~react_prev_q;

  // Free-running so the moment of the start press randomises the delay.
  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  assign wait_last = (32'(ms_cnt_q) + 32'd1 == 32'(delay_q));
  assign go_last   = (ms_cnt_q == 14'(MAX_MS - 1));

  // Every state entry restarts the ms so the first one is full length.
  assign tick_clr = (state_d != state_q);

  ms_tick_gen #(
    .MS_DIV (MS_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (ms_tick)
  );

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    delay_d  = delay_q;
    number_d = number_q;
    unique case (state_q)
      StIdle, StResult, StFalseStart: begin
        if (start_press) begin
          delay_d  = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);
          ms_cnt_d = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (react_press) begin
          number_d = ERR_CODE;
          state_d  = StFalseStart;
        end else if (ms_tick) begin
          if (wait_last) begin
            ms_cnt_d = '0;
            state_d  = StGo;
          end else begin
            ms_cnt_d = ms_cnt_q + 14'd1;
          end
        end
      end
      StGo: begin
        // The saturating tick beats a simultaneous react press.
        if (ms_tick && go_last) begin
          ms_cnt_d = 14'(MAX_MS);
          number_d = 16'(MAX_MS);
          state_d  = StResult;
        end else if (react_press) begin
          number_d = 16'(ms_cnt_q);
          state_d  = StResult;
        end else if (ms_tick) begin
          ms_cnt_d = ms_cnt_q + 14'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    led_go_d = (state_d == StGo);
    done_d   = (state_d == StResult) || (state_d == StFalseStart);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      react_prev_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      ms_cnt_q     <= '0;
      delay_q      <= '0;
      number_q     <= '0;
      done_q       <= 1'b0;
      led_go_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.btn_start;
      react_prev_q <= bus.btn_react;
      lfsr_q       <= lfsr_d;
      ms_cnt_q     <= ms_cnt_d;
      delay_q      <= delay_d;
      number_q     <= number_d;
      done_q       <= done_d;
      led_go_q     <= led_go_d;
    end
  end

  assign bus.led_go = led_go_q;
  assign bus.number = number_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl with a shortened ms.
module tb_reaction_timer_ctrl;

  localparam int unsigned MS_DIV       = 4;
  localparam int unsigned MIN_DELAY_MS = 2;
  localparam int unsigned RAND_BITS    = 2;
  localparam int unsigned MAX_MS       = 9999;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   asserts = 0;
  int   fails = 0;
  int   last_num = 0;
  logic [15:0] m_lfsr;

  reaction_timer_ctrl_if bus ();

  reaction_timer_ctrl #(
    .MS_DIV       (MS_DIV),
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .RAND_BITS    (RAND_BITS),
    .MAX_MS       (MAX_MS),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11 of a 16-bit Fibonacci register,
  // stepping once per clock independent of the game.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

  // Press start (optionally with react in the same cycle); returns the expected
  // delay in ms. Ends at the negedge of the first WAIT cycle.
  task automatic start_round(input bit with_react, output int d);
    @(negedge clk);
    bus.btn_start = 1'b1;
    if (with_react) bus.btn_react = 1'b1;
    d = int'(MIN_DELAY_MS) + (int'(m_lfsr) % (1 << RAND_BITS));
    @(negedge clk);
    bus.btn_start = 1'b0;
  endtask

  // Called at the negedge of WAIT cycle cnt0; ends at GO cycle 0.
  task automatic wait_go(input int d, input int cnt0, input string name);
    int cnt = cnt0;
    while (!bus.led_go && cnt < int'(MS_DIV) * d + 40) begin
      @(negedge clk);
      cnt++;
    end
    asserts++;
    if (cnt != int'(MS_DIV) * d) begin
      fails++;
      $display("FAIL %s go_latency: got %0d cycles, expected %0d", name, cnt, int'(MS_DIV) * d);
    end
  endtask

  // Called at GO cycle 0; react is detected in GO cycle w.
  task automatic react_in_go(input int w, input bit both, input string name);
    int expv = w / int'(MS_DIV);
    repeat (w) @(negedge clk);
    bus.btn_react = 1'b1;
    if (both) bus.btn_start = 1'b1;
    @(negedge clk);
    asserts += 3;
    if (bus.number !== 16'(expv)) begin
      fails++;
      $display("FAIL %s number: got %0d, expected %0d", name, bus.number, expv);
    end
    if (bus.done !== 1'b1) begin
      fails++;
      $display("FAIL %s done: got %b, expected 1", name, bus.done);
    end
    if (bus.led_go !== 1'b0) begin
      fails++;
      $display("FAIL %s led_go: got %b, expected 0", name, bus.led_go);
    end
    last_num = expv;
    bus.btn_react = 1'b0;
    bus.btn_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({bus.led_go, bus.done, bus.number} !== 18'd0) begin
      fails++;
      $display("FAIL reset outputs: got led_go=%b done=%b number=%h, expected all 0",
               bus.led_go, bus.done, bus.number);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    repeat (3) @(negedge clk);
    start_round(1'b0, d);
    wait_go(d, 0, "basic");
    react_in_go(21, 1'b0, "basic_5ms");
  endtask

  task automatic test_result_restart();
    int d;
    start_round(1'b0, d);
    asserts += 2;
    if (bus.number !== 16'(last_num)) begin
      fails++;
      $display("FAIL restart number_held: got %0d, expected %0d", bus.number, last_num);
    end
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL restart done: got %b, expected 0", bus.done);
    end
    // Start re-press during WAIT must not disturb the delay.
    @(negedge clk);
    bus.btn_start = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b0;
    wait_go(d, 2, "start_in_wait");
    react_in_go(6, 1'b0, "restart_react");
  endtask

  task automatic test_false_start(input bit at_last_tick);
    int d, r, go_seen;
    go_seen = 0;
    start_round(1'b0, d);
    r = at_last_tick ? int'(MS_DIV) * d - 1 : $urandom_range(0, int'(MS_DIV) * d - 1);
    repeat (r) begin
      @(negedge clk);
      if (bus.led_go) go_seen++;
    end
    bus.btn_react = 1'b1;
    @(negedge clk);
    asserts += 2;
    if (bus.number !== 16'hEEEE || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL false_start code: got number=%h done=%b, expected EEEE/1 (r=%0d)",
               bus.number, bus.done, r);
    end
    bus.btn_react = 1'b0;
    repeat (int'(MS_DIV) * d + 8) begin
      @(negedge clk);
      if (bus.led_go) go_seen++;
    end
    if (go_seen != 0 || bus.number !== 16'hEEEE) begin
      fails++;
      $display("FAIL false_start no_go: got go_cycles=%0d number=%h, expected 0/EEEE",
               go_seen, bus.number);
    end
    last_num = 16'hEEEE;
  endtask

  // Start and react together outside WAIT/GO: start wins, held react is inert.
  task automatic test_held_react();
    int d;
    start_round(1'b1, d);
    wait_go(d, 0, "held_react");
    bus.btn_react = 1'b0;
    react_in_go(9, 1'b0, "held_react_repress");
  endtask

  task automatic test_both_in_go();
    int d;
    start_round(1'b0, d);
    wait_go(d, 0, "both");
    react_in_go(13, 1'b1, "both_in_go");
  endtask

  task automatic test_timeout();
    int d, cnt;
    start_round(1'b0, d);
    wait_go(d, 0, "timeout");
    cnt = 0;
    while (!bus.done && cnt < int'(MS_DIV * MAX_MS) + 100) begin
      @(negedge clk);
      cnt++;
    end
    asserts += 2;
    if (cnt != int'(MS_DIV * MAX_MS)) begin
      fails++;
      $display("FAIL timeout latency: got %0d cycles, expected %0d", cnt, MS_DIV * MAX_MS);
    end
    if (bus.number !== 16'(MAX_MS) || bus.led_go !== 1'b0) begin
      fails++;
      $display("FAIL timeout value: got number=%0d led_go=%b, expected %0d/0",
               bus.number, bus.led_go, MAX_MS);
    end
    last_num = MAX_MS;
  endtask

  task automatic test_reset_in_go();
    int d, bad;
    bad = 0;
    start_round(1'b0, d);
    wait_go(d, 0, "reset_in_go");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    asserts += 2;
    if ({bus.led_go, bus.done, bus.number} !== 18'd0) begin
      fails++;
      $display("FAIL reset_in_go outputs: got led_go=%b done=%b number=%h, expected all 0",
               bus.led_go, bus.done, bus.number);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.led_go || bus.done) bad++;
    end
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_in_go idle: got %0d active cycles, expected 0", bad);
    end
    start_round(1'b0, d);
    wait_go(d, 0, "after_reset");
    react_in_go(2, 1'b0, "after_reset_react");
  endtask

  task automatic test_random(input int n);
    int d, w, mode;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        test_false_start(1'b0);
      end else begin
        start_round(1'b0, d);
        wait_go(d, 0, "random");
        w = $urandom_range(0, 40);
        if (w % int'(MS_DIV) == int'(MS_DIV) - 1) w++;
        react_in_go(w, mode == 2, "random_react");
      end
    end
  endtask

  initial begin
    bus.btn_start = 1'b0;
    bus.btn_react = 1'b0;
    test_reset();
    test_basic();
    test_result_restart();
    test_false_start(1'b0);
    test_false_start(1'b1);
    test_held_react();
    test_both_in_go();
    test_reset_in_go();
    test_random(10);
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
